ahb_key_ctrl: RTL

AHB-Lite slave on the Cortex-M0 bus that collects debounced per-key press pulses and exposes them to software as sticky pending bits and a maskable level interrupt. An optional event FIFO records press order. It sits between the bank of per-key debouncer instances, which produce one-cycle `key_output` pulses, and the M0 NVIC.

---
 rtl/ahb_key_pkg.sv | 42 ++++
 rtl/key_evt_fifo.sv | 86 ++++++++
 rtl/ahb_key_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_key_pkg.sv
// ---------------------------------------------------------------------------
// ahb_key_pkg
// Shared definitions for the AHB key controller slice:
//   - word offsets (HADDR[4:2]) of the register map
//   - event FIFO entry field widths and status field positions
//   - small helpers for picking the pushed key index out of a pulse vector
// Configuration macro used by the slice: AHB_KEY_FIFO_EN (event FIFO build).
// ---------------------------------------------------------------------------
package ahb_key_pkg;

    // Word offsets as seen on HADDR[4:2]
    localparam logic [2:0] KEY_PEND_OFS  = 3'd0;  // 0x00 PEND
    localparam logic [2:0] KEY_CLR_OFS   = 3'd1;  // 0x04 CLEAR
    localparam logic [2:0] KEY_IRQEN_OFS = 3'd2;  // 0x08 IRQEN
    localparam logic [2:0] KEY_FDATA_OFS = 3'd3;  // 0x0C FIFO_DATA
    localparam logic [2:0] KEY_FSTAT_OFS = 3'd4;  // 0x10 FIFO_STAT

    // FIFO entry: [4] valid, [3:0] key index
    localparam int KEY_IDX_W     = 4;
    localparam int KEY_ENTRY_W   = KEY_IDX_W + 1;
    localparam int KEY_VALID_BIT = 4;

    // FIFO_STAT: [5:0] count, [8] overflow
    localparam int KEY_CNT_W     = 6;
    localparam int KEY_OVF_BIT   = 8;

    // Index of the lowest set bit; 0 when no bit is set
    function automatic logic [KEY_IDX_W-1:0] first_set_idx(input logic [15:0] vec);
        logic [KEY_IDX_W-1:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            idx = vec[i] ? 4'(i) : idx;
        end
        return idx;
    endfunction

    // True when more than one bit of the vector is set
    function automatic logic multi_hot(input logic [15:0] vec);
        return (vec & (vec - 16'd1)) != 16'd0;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// ---------------------------------------------------------------------------
// key_evt_fifo
// Synchronous FIFO recording key-press indices in arrival order.
// A push while full is dropped (drop strobe) unless a pop frees a slot in the
// same cycle. A pop while empty is ignored and leaves the pointers alone.
// Only instantiated when AHB_KEY_FIFO_EN is defined.
// Ports:
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   push, push_data enqueue request and key index
//   pop             dequeue request
//   head_data       entry at the head of the queue
//   count           number of stored entries (0..DEPTH)
//   full, empty     occupancy flags
//   drop            push rejected this cycle because the FIFO was full
// ---------------------------------------------------------------------------
module key_evt_fifo
    import ahb_key_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = KEY_IDX_W
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_s;
    logic          empty_s;
    logic          rd_ok_s;
    logic          wr_ok_s;

    assign full_s  = (count_r == CW'(DEPTH));
    assign empty_s = (count_r == {CW{1'b0}});
    assign rd_ok_s = pop & ~empty_s;
    // a same-cycle pop frees a slot, so a push into a full FIFO still lands
    assign wr_ok_s = push & (~full_s | rd_ok_s);

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign full      = full_s;
    assign empty     = empty_s;
    assign drop      = push & full_s & ~rd_ok_s;

    // Entry storage; contents are meaningless until the pointers say otherwise
    always_ff @(posedge HCLK) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ahb_key_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_key_ctrl
// AHB-Lite slave collecting debounced key press pulses into sticky pending
// bits with a maskable, registered level interrupt, plus an optional event
// FIFO recording press order (built when AHB_KEY_FIFO_EN is defined).
// Ports:
//   HCLK, HRESETn          bus clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,   AHB-Lite address phase (only HADDR[4:2] decoded,
//   HWRITE, HSIZE, HREADY  HSIZE ignored)
//   HWDATA                 write data (data phase)
//   HREADYOUT, HRESP       always ready, always OKAY
//   HRDATA                 read data (data phase, combinational)
//   key_pulse              one-cycle press pulses, one per key
//   key_irq                level interrupt, |(PEND & IRQEN), registered
// Register map: 0x00 PEND (RO), 0x04 CLEAR (W1C), 0x08 IRQEN (RW),
//               0x0C FIFO_DATA (read pops), 0x10 FIFO_STAT (count, ovf W1C)
// ---------------------------------------------------------------------------
module ahb_key_ctrl
    import ahb_key_pkg::*;
#(
    parameter int KEY_NUM    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               HSEL,
    input  logic [31:0]        HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [31:0]        HWDATA,
    input  logic               HREADY,
    output logic               HREADYOUT,
    output logic               HRESP,
    output logic [31:0]        HRDATA,
    input  logic [KEY_NUM-1:0] key_pulse,
    output logic               key_irq
);

    logic               wr_en_r;
    logic               rd_en_r;
    logic [2:0]         addr_r;
    logic [KEY_NUM-1:0] pend_r;
    logic [KEY_NUM-1:0] irqen_r;
    logic               key_irq_r;
    logic               wr_clr_s;
    logic               wr_irqen_s;
    logic [KEY_NUM-1:0] clr_mask_s;
    logic [31:0]        fdata_s;
    logic [31:0]        fstat_s;
    logic [31:0]        rdata_s;
    logic               unused_s;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign HRDATA    = rdata_s;
    assign key_irq   = key_irq_r;

    // Bus inputs that carry no information for this slave
    assign unused_s = ^{HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

    // Address phase capture; the data phase uses these on the following cycle
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_en_r <= 1'b0;
            rd_en_r <= 1'b0;
            addr_r  <= 3'd0;
        end else if (HREADY) begin
            wr_en_r <= HSEL & HTRANS[1] & HWRITE;
            rd_en_r <= HSEL & HTRANS[1] & ~HWRITE;
            addr_r  <= HADDR[4:2];
        end
    end

    assign wr_clr_s   = wr_en_r & (addr_r == KEY_CLR_OFS);
    assign wr_irqen_s = wr_en_r & (addr_r == KEY_IRQEN_OFS);
    assign clr_mask_s = wr_clr_s ? HWDATA[KEY_NUM-1:0] : {KEY_NUM{1'b0}};

    // Pending bits: clear first, then OR in new pulses so a same-cycle set wins
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_r <= {KEY_NUM{1'b0}};
        end else begin
            pend_r <= (pend_r & ~clr_mask_s) | key_pulse;
        end
    end

    // Interrupt mask register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irqen_r <= {KEY_NUM{1'b0}};
        end else if (wr_irqen_s) begin
            irqen_r <= HWDATA[KEY_NUM-1:0];
        end
    end

    // Registered level interrupt, one edge behind the pending/mask state
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            key_irq_r <= 1'b0;
        end else begin
            key_irq_r <= |(pend_r & irqen_r);
        end
    end

`ifdef AHB_KEY_FIFO_EN
    logic [KEY_IDX_W-1:0]         push_idx_s;
    logic [KEY_IDX_W-1:0]         head_s;
    logic [$clog2(FIFO_DEPTH):0]  cnt_s;
    logic                         push_s;
    logic                         pop_s;
    logic                         multi_s;
    logic                         drop_s;
    logic                         full_s;
    logic                         empty_s;
    logic                         ovf_set_s;
    logic                         ovf_clr_s;
    logic                         ovf_r;
    logic                         unused_fifo_s;

    // Only the lowest-index pulse is queued; the rest only flag overflow
    assign push_idx_s    = first_set_idx(16'(key_pulse));
    assign push_s        = |key_pulse;
    assign multi_s       = multi_hot(16'(key_pulse));
    // The FIFO itself ignores a pop while empty
    assign pop_s         = rd_en_r & (addr_r == KEY_FDATA_OFS);
    assign ovf_set_s     = drop_s | multi_s;
    assign ovf_clr_s     = wr_en_r & (addr_r == KEY_FSTAT_OFS) & HWDATA[KEY_OVF_BIT];
    assign unused_fifo_s = full_s;

    key_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (KEY_IDX_W)
    ) u_fifo (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .push      (push_s),
        .push_data (push_idx_s),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (cnt_s),
        .full      (full_s),
        .empty     (empty_s),
        .drop      (drop_s)
    );

    // Sticky overflow flag; a new overflow event beats a same-cycle clear
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr_s) begin
            ovf_r <= 1'b0;
        end
    end

    assign fdata_s = empty_s ? 32'd0 : 32'({1'b1, head_s});
    assign fstat_s = 32'({ovf_r, 2'b00, KEY_CNT_W'(cnt_s)});
`else
    assign fdata_s = 32'd0;
    assign fstat_s = 32'd0;
`endif

    // Data-phase read mux from the registered address and current state
    always_comb begin
        rdata_s = 32'd0;
        if (rd_en_r) begin
            case (addr_r)
                KEY_PEND_OFS:  rdata_s = 32'(pend_r);
                KEY_IRQEN_OFS: rdata_s = 32'(irqen_r);
                KEY_FDATA_OFS: rdata_s = fdata_s;
                KEY_FSTAT_OFS: rdata_s = fstat_s;
                default:       rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

endmodule
